io_port_hub: RTL and testbench
==============================

Name: io_port_hub

Overview:
- Parametrised port-mapped I/O subsystem between the RAT MCU port bus (PORT_ID / OUT_PORT / IO_STRB / IN_PORT) and board peripherals.
- Provides:
  - NUM_OUT addressable output registers, each with a write-strobe pulse.
  - NUM_IN addressable input ports.
  - A maskable, edge-triggered interrupt controller with sticky pending bits.
- Replaces the hand-coded per-wrapper port mux, and drives the MCU INTERRUPT input.

Parameters:
- DATA_W, 8: port data width.
- NUM_OUT, 4: number of output registers. Range 1..16.
- OUT_BASE_ID, 8'h40: port ID of output register 0. Register k is at OUT_BASE_ID+k.
- NUM_IN, 4: number of input ports. Range 1..16.
- IN_BASE_ID, 8'h20: port ID of input port 0. Port k is at IN_BASE_ID+k.
- NUM_IRQ, 4: number of interrupt sources. Must satisfy NUM_IRQ <= DATA_W.
- IRQ_STATUS_ID, 8'hF0: read address of the pending register.
- IRQ_MASK_ID, 8'hF1: read/write address of the mask register.
- IRQ_CLR_ID, 8'hF2: write-one-to-clear address for pending bits.
- SYNC_STAGES, 2: synchroniser depth on IRQ_SRC. Must be >= 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- PORT_ID  in  8  MCU port address.
- OUT_PORT  in  DATA_W  MCU write data.
- IO_STRB  in  1  MCU write strobe; one cycle per OUT instruction.
- IN_PORT  out  DATA_W  read data returned to the MCU (combinational).
- IN_DATA  in  NUM_IN*DATA_W  peripheral inputs; port k occupies slice [k*DATA_W +: DATA_W].
- OUT_DATA  out  NUM_OUT*DATA_W  output registers; same slicing as IN_DATA.
- OUT_WR  out  NUM_OUT  one-cycle pulse per output register on each write to it.
- IRQ_SRC  in  NUM_IRQ  asynchronous interrupt request levels.
- INTERRUPT  out  1  registered interrupt request to the MCU.

Behaviour:
- Clock and reset:
  - Single clock domain, CLK.
  - RESET is synchronous and active-high; it takes effect at the rising CLK edge where RESET=1.
- Reset values:
  - OUT_DATA = 0, OUT_WR = 0, pending = 0, mask = 0, INTERRUPT = 0.
  - All synchroniser and edge-history flops = 0.
- Reset mid-operation:
  - RESET overrides any write, clear or edge in the same cycle.
  - An IRQ_SRC held high through reset release is seen as a rising edge SYNC_STAGES+1 cycles after release. This is intended.
- Address decode priority: IRQ_STATUS_ID / IRQ_MASK_ID / IRQ_CLR_ID, then the output range, then the input range.
  - Overlapping ranges are a configuration error and are not checked.
- Writes (IO_STRB=1, decoded at the rising edge):
  - Output register k: OUT_DATA slice k <= OUT_PORT, and OUT_WR[k]=1 for exactly the following cycle.
  - Back-to-back strobes to the same register: OUT_WR stays high both cycles; data follows each write.
  - IRQ_MASK_ID: mask <= OUT_PORT[NUM_IRQ-1:0].
  - IRQ_CLR_ID: pending <= pending & ~OUT_PORT[NUM_IRQ-1:0].
  - IRQ_STATUS_ID, input-range IDs and unmapped IDs: no effect.
  - IO_STRB=0: no state change; OUT_WR = 0.
- Reads (combinational, zero latency, independent of IO_STRB):
  - IN_BASE_ID+k returns slice k of IN_DATA.
  - IRQ_STATUS_ID returns pending, zero-extended.
  - IRQ_MASK_ID returns mask, zero-extended.
  - All other IDs, including the output range and IRQ_CLR_ID, return 0.
- Interrupt path, per source i:
  - IRQ_SRC[i] passes through a SYNC_STAGES flop chain, then a history flop.
  - Edge = synchronised & ~history.
  - An edge sets pending[i]. Pending is sticky until cleared by software.
  - If an edge and a clear hit the same bit in the same cycle, set wins and the bit stays 1.
  - Pending bits set regardless of mask.
  - INTERRUPT <= |(pending & mask), registered. It rises one cycle after the pending/mask update that makes the term nonzero.
  - A mask write that unmasks an already-pending bit asserts INTERRUPT one cycle after the write.
  - Latency from an IRQ_SRC rising edge (sampled at a CLK edge) to INTERRUPT=1 is SYNC_STAGES+2 cycles, mask already set.
- Arithmetic: range decodes use PORT_ID - BASE < NUM, 8-bit unsigned.
  - No wrap: BASE+NUM-1 must be <= 8'hFF. An elaboration assertion enforces this, plus NUM_IRQ <= DATA_W and SYNC_STAGES >= 2.

Test Plan:
- Reset and write: RESET pulse; strobe PORT_ID=8'h42, OUT_PORT=8'hA5 -> OUT_DATA slice 2 = 8'hA5, OUT_WR=4'b0100 for one cycle, other slices stay 0.
- Read mux: IN_DATA = 32'h44332211; PORT_ID = 8'h23, then 8'h24, then 8'h99 -> IN_PORT = 8'h44, then 8'h00, then 8'h00.
- Interrupt latency: mask=4'b0010; IRQ_SRC[1] rises -> INTERRUPT=1 exactly 4 cycles later (SYNC_STAGES=2); status read = 8'h02.
- Clear vs. new edge: write 8'h02 to IRQ_CLR_ID in the same cycle a new edge on source 1 reaches the edge detector -> pending[1] stays 1, INTERRUPT stays 1.
- Masked pending: edge on source 3 with mask=0 -> pending=8'h08, INTERRUPT=0; write mask 8'h08 -> INTERRUPT=1 one cycle later; clear 8'h08 -> INTERRUPT=0 one cycle after the clear.
- Reset mid-operation: assert RESET in the same cycle as an output write and a pending edge -> all outputs 0 next cycle, write discarded.

Source files
------------

// File: rtl/io_port_hub.sv
`default_nettype none
// ============================================================================
//  Module   : io_port_hub
//  Brief    : Port-mapped I/O hub for the RAT MCU port bus. Provides
//             addressable output registers with write-strobe pulses,
//             addressable input ports and an edge-triggered, maskable
//             interrupt controller with sticky pending bits.
//  Revision : 1.0 - initial release
// ============================================================================
module io_port_hub #(
    parameter int         DATA_W        = 8,
    parameter int         NUM_OUT       = 4,
    parameter logic [7:0] OUT_BASE_ID   = 8'h40,
    parameter int         NUM_IN        = 4,
    parameter logic [7:0] IN_BASE_ID    = 8'h20,
    parameter int         NUM_IRQ       = 4,
    parameter logic [7:0] IRQ_STATUS_ID = 8'hF0,
    parameter logic [7:0] IRQ_MASK_ID   = 8'hF1,
    parameter logic [7:0] IRQ_CLR_ID    = 8'hF2,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [7:0]                  PORT_ID,
    input  logic [DATA_W-1:0]           OUT_PORT,
    input  logic                        IO_STRB,
    output logic [DATA_W-1:0]           IN_PORT,
    input  logic [NUM_IN*DATA_W-1:0]    IN_DATA,
    output logic [NUM_OUT*DATA_W-1:0]   OUT_DATA,
    output logic [NUM_OUT-1:0]          OUT_WR,
    input  logic [NUM_IRQ-1:0]          IRQ_SRC,
    output logic                        INTERRUPT
);

    // ------------------------------------------------------------------------
    // Configuration sanity checks, evaluated at elaboration
    // ------------------------------------------------------------------------
    if ((NUM_OUT < 1) || (NUM_OUT > 16)) begin : g_chk_num_out
        $error("io_port_hub: NUM_OUT must be in 1..16");
    end
    if ((NUM_IN < 1) || (NUM_IN > 16)) begin : g_chk_num_in
        $error("io_port_hub: NUM_IN must be in 1..16");
    end
    if ((int'(OUT_BASE_ID) + NUM_OUT - 1) > 255) begin : g_chk_out_wrap
        $error("io_port_hub: output range wraps past 8'hFF");
    end
    if ((int'(IN_BASE_ID) + NUM_IN - 1) > 255) begin : g_chk_in_wrap
        $error("io_port_hub: input range wraps past 8'hFF");
    end
    if ((NUM_IRQ < 1) || (NUM_IRQ > DATA_W)) begin : g_chk_num_irq
        $error("io_port_hub: NUM_IRQ must be in 1..DATA_W");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("io_port_hub: SYNC_STAGES must be >= 2");
    end

    localparam logic [7:0] c_num_out = 8'(NUM_OUT);
    localparam logic [7:0] c_num_in  = 8'(NUM_IN);

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic [7:0]               w_out_off;
    logic [7:0]               w_in_off;
    logic                     w_is_status;
    logic                     w_is_mask;
    logic                     w_is_clr;
    logic                     w_is_irq;
    logic                     w_out_sel;
    logic                     w_in_sel;

    // Range offsets are 8-bit unsigned; an ID below the base wraps to a large
    // offset and therefore falls outside the range without a second compare.
    assign w_out_off   = PORT_ID - OUT_BASE_ID;
    assign w_in_off    = PORT_ID - IN_BASE_ID;
    assign w_is_status = (PORT_ID == IRQ_STATUS_ID);
    assign w_is_mask   = (PORT_ID == IRQ_MASK_ID);
    assign w_is_clr    = (PORT_ID == IRQ_CLR_ID);
    assign w_is_irq    = w_is_status | w_is_mask | w_is_clr;
    // Interrupt registers win over the output range, which wins over inputs.
    assign w_out_sel   = ~w_is_irq & (w_out_off < c_num_out);
    assign w_in_sel    = ~w_is_irq & ~w_out_sel & (w_in_off < c_num_in);

    // ------------------------------------------------------------------------
    // Output registers and write strobes
    // ------------------------------------------------------------------------
    logic [NUM_OUT-1:0]       w_out_we;
    logic [NUM_OUT-1:0]       r_out_wr;
    logic [DATA_W-1:0]        r_out_data [NUM_OUT];

    // One-hot write enable for the addressed output register.
    always_comb begin
        w_out_we = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (IO_STRB && w_out_sel && (w_out_off == 8'(k))) begin
                w_out_we[k] = 1'b1;
            end
        end
    end

    // Capture write data and register the per-register strobe pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_wr <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_out_data[k] <= '0;
            end
        end else begin
            r_out_wr <= w_out_we;
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_out_we[k]) begin
                    r_out_data[k] <= OUT_PORT;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out_pack
        assign OUT_DATA[k*DATA_W +: DATA_W] = r_out_data[k];
    end

    assign OUT_WR = r_out_wr;

    // ------------------------------------------------------------------------
    // Interrupt controller
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
    logic [NUM_IRQ-1:0]       r_hist;
    logic [NUM_IRQ-1:0]       r_pending;
    logic [NUM_IRQ-1:0]       r_mask;
    logic                     r_interrupt;
    logic [NUM_IRQ-1:0]       w_edge;
    logic [NUM_IRQ-1:0]       w_clr_bits;

    assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_clr_bits = (IO_STRB && w_is_clr) ? OUT_PORT[NUM_IRQ-1:0] : '0;

    // Synchronise the asynchronous request levels and keep one cycle of history.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync <= '0;
            r_hist <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], IRQ_SRC};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // Sticky pending bits: a new edge beats a same-cycle software clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_bits) | w_edge;
        end
    end

    // Software-writable interrupt mask.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mask <= '0;
        end else if (IO_STRB && w_is_mask) begin
            r_mask <= OUT_PORT[NUM_IRQ-1:0];
        end
    end

    // Registered MCU interrupt request from any enabled pending source.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_interrupt <= 1'b0;
        end else begin
            r_interrupt <= |(r_pending & r_mask);
        end
    end

    assign INTERRUPT = r_interrupt;

    // ------------------------------------------------------------------------
    // Read mux (combinational, independent of IO_STRB)
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]        w_rd_data;

    // Select pending, mask or an input slice; everything else reads as zero.
    always_comb begin
        w_rd_data = '0;
        if (w_is_status) begin
            w_rd_data = DATA_W'(r_pending);
        end else if (w_is_mask) begin
            w_rd_data = DATA_W'(r_mask);
        end else if (w_in_sel) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (w_in_off == 8'(k)) begin
                    w_rd_data = IN_DATA[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign IN_PORT = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_io_port_hub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_port_hub
//  Brief    : Self-checking directed bench for io_port_hub (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_port_hub;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  PORT_ID;
    logic [7:0]  OUT_PORT;
    logic        IO_STRB;
    logic [7:0]  IN_PORT;
    logic [31:0] IN_DATA;
    logic [31:0] OUT_DATA;
    logic [3:0]  OUT_WR;
    logic [3:0]  IRQ_SRC;
    logic        INTERRUPT;

    always #5 CLK = ~CLK;

    io_port_hub dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PORT_ID   (PORT_ID),
        .OUT_PORT  (OUT_PORT),
        .IO_STRB   (IO_STRB),
        .IN_PORT   (IN_PORT),
        .IN_DATA   (IN_DATA),
        .OUT_DATA  (OUT_DATA),
        .OUT_WR    (OUT_WR),
        .IRQ_SRC   (IRQ_SRC),
        .INTERRUPT (INTERRUPT)
    );

    int          checks = 0;
    int          errors = 0;
    string       exp_tag [$];
    logic [31:0] exp_val [$];

    // Scoreboard: expectations are queued when stimulus is applied.
    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_tag.push_back(tag);
        exp_val.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with the observed value.
    task automatic pop_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        checks++;
        if (exp_val.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected none", obs);
            return;
        end
        tag = exp_tag.pop_front();
        e   = exp_val.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // Advance one clock; stimulus and sampling happen 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle strobed write; returns just after the capturing edge.
    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
    endtask

    // Combinational read check on IN_PORT.
    task automatic rd_check(input string tag, input logic [7:0] id, input logic [7:0] v);
        expect_val(tag, {24'h0, v});
        PORT_ID = id;
        #1;
        pop_check({24'h0, IN_PORT});
    endtask

    task automatic sig_check(input string tag, input logic [31:0] v, input logic [31:0] obs);
        expect_val(tag, v);
        pop_check(obs);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET    = 1'b1;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        IO_STRB  = 1'b0;
        IN_DATA  = 32'h0;
        IRQ_SRC  = 4'h0;
        repeat (2) tick();
        RESET = 1'b0;

        // Reset state
        sig_check("rst_out_data", 32'h0, OUT_DATA);
        sig_check("rst_out_wr", 32'h0, {28'h0, OUT_WR});
        sig_check("rst_interrupt", 32'h0, {31'h0, INTERRUPT});
        rd_check("rst_status", 8'hF0, 8'h00);
        rd_check("rst_mask", 8'hF1, 8'h00);

        // Single write to register 2
        wr(8'h42, 8'hA5);
        sig_check("wr2_data", 32'h00A5_0000, OUT_DATA);
        sig_check("wr2_strobe", 32'h4, {28'h0, OUT_WR});
        tick();
        sig_check("wr2_strobe_end", 32'h0, {28'h0, OUT_WR});
        sig_check("wr2_data_hold", 32'h00A5_0000, OUT_DATA);

        // Back-to-back writes to register 0
        PORT_ID  = 8'h40;
        OUT_PORT = 8'h11;
        IO_STRB  = 1'b1;
        tick();
        sig_check("b2b_wr_1", 32'h1, {28'h0, OUT_WR});
        sig_check("b2b_data_1", 32'h00A5_0011, OUT_DATA);
        OUT_PORT = 8'h22;
        tick();
        sig_check("b2b_wr_2", 32'h1, {28'h0, OUT_WR});
        sig_check("b2b_data_2", 32'h00A5_0022, OUT_DATA);
        IO_STRB = 1'b0;
        tick();
        sig_check("b2b_wr_end", 32'h0, {28'h0, OUT_WR});

        // Top register, then IDs that must not write anything
        wr(8'h43, 8'hC3);
        sig_check("wr3_data", 32'hC3A5_0022, OUT_DATA);
        sig_check("wr3_strobe", 32'h8, {28'h0, OUT_WR});
        wr(8'h44, 8'h77);
        sig_check("wr_past_range_data", 32'hC3A5_0022, OUT_DATA);
        sig_check("wr_past_range_strobe", 32'h0, {28'h0, OUT_WR});
        wr(8'h21, 8'hFF);
        sig_check("wr_in_range_data", 32'hC3A5_0022, OUT_DATA);
        wr(8'hF0, 8'hFF);
        rd_check("wr_status_noeffect", 8'hF0, 8'h00);

        // Read mux
        IN_DATA = 32'h4433_2211;
        rd_check("rd_in3", 8'h23, 8'h44);
        rd_check("rd_past_in", 8'h24, 8'h00);
        rd_check("rd_unmapped", 8'h99, 8'h00);
        rd_check("rd_in0", 8'h20, 8'h11);
        rd_check("rd_out_range", 8'h42, 8'h00);
        rd_check("rd_clr_id", 8'hF2, 8'h00);

        // Interrupt latency with mask already set
        wr(8'hF1, 8'h02);
        rd_check("mask_rb", 8'hF1, 8'h02);
        IRQ_SRC = 4'b0010;
        expect_val("irq_lat_c1", 32'h0);
        expect_val("irq_lat_c2", 32'h0);
        expect_val("irq_lat_c3", 32'h0);
        expect_val("irq_lat_c4", 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            pop_check({31'h0, INTERRUPT});
        end
        rd_check("irq_status", 8'hF0, 8'h02);

        // Clear in the same cycle a new edge on source 1 reaches the detector
        IRQ_SRC = 4'b0000;
        repeat (3) tick();
        IRQ_SRC = 4'b0010;
        repeat (2) tick();
        PORT_ID  = 8'hF2;
        OUT_PORT = 8'h02;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
        rd_check("clr_vs_edge_status", 8'hF0, 8'h02);
        sig_check("clr_vs_edge_int", 32'h1, {31'h0, INTERRUPT});
        tick();
        sig_check("clr_vs_edge_int_next", 32'h1, {31'h0, INTERRUPT});

        // Masked pending, unmask, then clear
        wr(8'hF1, 8'h00);
        wr(8'hF2, 8'h02);
        sig_check("plain_clr_int", 32'h0, {31'h0, INTERRUPT});
        rd_check("plain_clr_status", 8'hF0, 8'h00);
        IRQ_SRC = 4'b1010;
        repeat (3) tick();
        rd_check("masked_status", 8'hF0, 8'h08);
        sig_check("masked_int", 32'h0, {31'h0, INTERRUPT});
        tick();
        sig_check("masked_int_hold", 32'h0, {31'h0, INTERRUPT});
        wr(8'hF1, 8'h08);
        sig_check("unmask_int_same", 32'h0, {31'h0, INTERRUPT});
        tick();
        sig_check("unmask_int_next", 32'h1, {31'h0, INTERRUPT});
        wr(8'hF2, 8'h08);
        sig_check("clr3_int_same", 32'h1, {31'h0, INTERRUPT});
        rd_check("clr3_status", 8'hF0, 8'h00);
        tick();
        sig_check("clr3_int_next", 32'h0, {31'h0, INTERRUPT});

        // Reset coinciding with an output write and a pending edge
        wr(8'hF1, 8'h0F);
        IRQ_SRC = 4'b1011;
        repeat (2) tick();
        RESET    = 1'b1;
        PORT_ID  = 8'h41;
        OUT_PORT = 8'h5A;
        IO_STRB  = 1'b1;
        tick();
        RESET   = 1'b0;
        IO_STRB = 1'b0;
        sig_check("midrst_out_data", 32'h0, OUT_DATA);
        sig_check("midrst_out_wr", 32'h0, {28'h0, OUT_WR});
        sig_check("midrst_int", 32'h0, {31'h0, INTERRUPT});
        rd_check("midrst_status", 8'hF0, 8'h00);
        rd_check("midrst_mask", 8'hF1, 8'h00);

        // Sources held high through release appear SYNC_STAGES+1 cycles later
        repeat (2) tick();
        rd_check("release_status_early", 8'hF0, 8'h00);
        tick();
        rd_check("release_status", 8'hF0, 8'h0B);
        tick();
        sig_check("release_int_masked", 32'h0, {31'h0, INTERRUPT});

        checks++;
        assert (exp_val.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_val.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
